// File: rtl/mem_stage.sv
// MEM stage of the five-stage MIPS pipeline: holds one instruction behind a
// valid/allowin handshake, formats SRAM load data and forwards results to decode.
module mem_stage (
  input  logic         clk,
  input  logic         reset,
  input  logic         es_to_ms_valid,
  input  logic [159:0] es_to_ms_bus,
  output logic         ms_allowin,
  input  logic         ws_allowin,
  output logic         ms_to_ws_valid,
  output logic [122:0] ms_to_ws_bus,
  input  logic [31:0]  data_sram_rdata,
  input  logic         ws_ex,
  input  logic         ws_eret,
  output logic [42:0]  ms_to_ds_bus,
  output logic         ms_cancel
);

  localparam logic [2:0] LD_NONE = 3'd0;
  localparam logic [2:0] LD_LB   = 3'd1;
  localparam logic [2:0] LD_LBU  = 3'd2;
  localparam logic [2:0] LD_LH   = 3'd3;
  localparam logic [2:0] LD_LHU  = 3'd4;
  localparam logic [2:0] LD_LW   = 3'd5;
  localparam logic [2:0] LD_LWL  = 3'd6;
  localparam logic [2:0] LD_LWR  = 3'd7;

  // Handshake: a transfer happens on a rising edge where the producer's valid
  // and the consumer's allowin are both 1; a producer holds its bus stable
  // while valid is high and allowin is low.
  logic         ms_valid;
  logic         ms_ready_go;
  logic         flush;
  logic [159:0] bus_r;

  logic [31:0]  badvaddr;
  logic [10:0]  c0_bus;
  logic         c0_eret;
  logic         c0_mfc0;
  logic         bd;
  logic         ex;
  logic [4:0]   excode;
  logic [31:0]  rt_value;
  logic [2:0]   ld_type;
  logic [1:0]   addr_lo;
  logic [3:0]   rf_we;
  logic [4:0]   dest;
  logic [31:0]  alu_result;
  logic [31:0]  pc;

  logic [7:0]   byte_sel;
  logic [15:0]  half_sel;
  logic [31:0]  lwl_data;
  logic [31:0]  lwr_data;
  logic [31:0]  load_data;
  logic [31:0]  final_result;

  assign flush       = ws_ex | ws_eret;
  assign ms_ready_go = 1'b1;
  assign ms_allowin  = !ms_valid || (ms_ready_go && ws_allowin);

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid <= 1'b0;
    end else if (flush) begin
      ms_valid <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid <= es_to_ms_valid;
    end
  end

  // Contents only matter while ms_valid is set, so no reset is needed.
  always_ff @(posedge clk) begin
    if (es_to_ms_valid && ms_allowin) begin
      bus_r <= es_to_ms_bus;
    end
  end

  assign badvaddr   = bus_r[159:128];
  assign c0_bus     = bus_r[127:117];
  assign c0_eret    = bus_r[127];
  assign c0_mfc0    = bus_r[125];
  assign bd         = bus_r[116];
  assign ex         = bus_r[115];
  assign excode     = bus_r[114:110];
  assign rt_value   = bus_r[109:78];
  assign ld_type    = bus_r[77:75];
  assign addr_lo    = bus_r[74:73];
  assign rf_we      = bus_r[72:69];
  assign dest       = bus_r[68:64];
  assign alu_result = bus_r[63:32];
  assign pc         = bus_r[31:0];

  // Little-endian lane selection plus the unaligned-word merges.
  always_comb begin
    byte_sel = data_sram_rdata[7:0];
    lwl_data = data_sram_rdata;
    lwr_data = data_sram_rdata;
    case (addr_lo)
      2'd0: begin
        byte_sel = data_sram_rdata[7:0];
        lwl_data = {data_sram_rdata[7:0], rt_value[23:0]};
        lwr_data = data_sram_rdata;
      end
      2'd1: begin
        byte_sel = data_sram_rdata[15:8];
        lwl_data = {data_sram_rdata[15:0], rt_value[15:0]};
        lwr_data = {rt_value[31:24], data_sram_rdata[31:8]};
      end
      2'd2: begin
        byte_sel = data_sram_rdata[23:16];
        lwl_data = {data_sram_rdata[23:0], rt_value[7:0]};
        lwr_data = {rt_value[31:16], data_sram_rdata[31:16]};
      end
      default: begin
        byte_sel = data_sram_rdata[31:24];
        lwl_data = data_sram_rdata;
        lwr_data = {rt_value[31:8], data_sram_rdata[31:24]};
      end
    endcase
    half_sel = addr_lo[1] ? data_sram_rdata[31:16] : data_sram_rdata[15:0];
  end

  always_comb begin
    load_data = data_sram_rdata;
    case (ld_type)
      LD_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  load_data = {24'd0, byte_sel};
      LD_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  load_data = {16'd0, half_sel};
      LD_LW:   load_data = data_sram_rdata;
      LD_LWL:  load_data = lwl_data;
      LD_LWR:  load_data = lwr_data;
      default: load_data = data_sram_rdata;
    endcase
  end

  assign final_result = (ld_type != LD_NONE) ? load_data : alu_result;

  assign ms_to_ws_valid = ms_valid && ms_ready_go && !flush;
  assign ms_to_ws_bus   = {badvaddr, c0_bus, bd, ex, excode,
                           rf_we, dest, final_result, pc};

  // mfc0_block stalls decode: the CP0 read value only exists in WB.
  assign ms_to_ds_bus = {ms_valid,
                         ms_valid && c0_mfc0,
                         {4{ms_valid && !ex}} & rf_we,
                         dest,
                         final_result};

  assign ms_cancel = ms_valid && (ex || c0_eret);

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage of the five-stage MIPS core, sitting between EXE and WB. Holds one instruction at a time behind a valid/allowin handshake, formats load data returned by the synchronous data SRAM (including unaligned LWL/LWR merge), and forwards the result to decode. It packs everything WB needs, including exception and CP0 side information, into the MEM-to-WB bus, and drains itself on WB exception or ERET flush.

## Interface
- No parameters; bus widths are fixed: ES_TO_MS_BUS_WD = 160, MS_TO_WS_BUS_WD = 123, MS_TO_DS_BUS_WD = 43.
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high
- es_to_ms_valid  in  1  EXE holds a valid instruction
- es_to_ms_bus  in  160  badvaddr[159:128], c0_bus[127:117] (eret 127, mtc0 126, mfc0 125, c0_raddr 124:117), bd[116], ex[115], excode[114:110], rt_value[109:78], ld_type[77:75], addr_lo[74:73], rf_we[72:69], dest[68:64], alu_result[63:32], pc[31:0]
- ms_allowin  out  1  MEM accepts a new instruction this cycle
- ws_allowin  in  1  WB accepts this cycle
- ms_to_ws_valid  out  1  MEM presents a valid instruction to WB
- ms_to_ws_bus  out  123  badvaddr[122:91], c0_bus[90:80], bd[79], ex[78], excode[77:73], rf_we[72:69], dest[68:64], final_result[63:32], pc[31:0]
- data_sram_rdata  in  32  read data for the address EXE issued one cycle earlier
- ws_ex  in  1  WB commits an exception (already qualified by WB valid)
- ws_eret  in  1  WB commits an ERET (already qualified by WB valid)
- ms_to_ds_bus  out  43  fwd_valid[42], mfc0_block[41], fwd_we[40:37], fwd_dest[36:32], fwd_data[31:0]
- ms_cancel  out  1  to EXE: the instruction in MEM has an exception or is an ERET; EXE suppresses store issue

## Operation
- ld_type: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWL, 7 LWR. The byte lane is selected by addr_lo (little-endian).
- LB/LBU: byte m[8*addr_lo +: 8], sign- or zero-extended. LH/LHU: addr_lo[1] selects the half (m[15:0] or m[31:16]), sign- or zero-extended. LW: m.
- LWL by addr_lo 0..3: {m[7:0],rt[23:0]}, {m[15:0],rt[15:0]}, {m[23:0],rt[7:0]}, m.
- LWR by addr_lo 0..3: m, {rt[31:24],m[31:8]}, {rt[31:16],m[31:16]}, {rt[31:8],m[31:24]}.
- final_result = formatted load data when ld_type != 0; otherwise alu_result.
- All other ms_to_ws_bus fields pass through unchanged from the latched es_to_ms_bus. rf_we is passed as latched; the full-word merge makes partial enables unnecessary.
- Pipeline register: latch es_to_ms_bus when es_to_ms_valid && ms_allowin.
- ms_ready_go = 1. ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
- ms_valid update, in priority order: reset -> 0; ws_ex || ws_eret -> 0; ms_allowin -> es_to_ms_valid.
- ms_to_ws_valid = ms_valid && ms_ready_go && !(ws_ex || ws_eret).
- Forwarding bus:
  - fwd_valid = ms_valid.
  - fwd_we = {4{ms_valid && !ex}} & rf_we.
  - fwd_dest = dest.
  - fwd_data = final_result.
  - mfc0_block = ms_valid && mfc0. Decode stalls because the CP0 value is produced only in WB.
- ms_cancel = ms_valid && (ex || c0_bus eret bit).

## Timing
- Reset values: ms_valid=0, ms_to_ws_valid=0, ms_allowin=1, ms_cancel=0, fwd_we=0, fwd_valid=0, mfc0_block=0. The bus register contents are don't-care but are never observed while invalid.
- Latency: 1 cycle EXE->MEM. data_sram_rdata is sampled combinationally in the same cycle the instruction is valid in MEM.
- Stall: ws_allowin=0 with ms_valid=1 holds the bus register and ms_valid. The SRAM must hold rdata (EXE does not reissue while ms_allowin=0).
- Flush: a cycle with ws_ex or ws_eret forces ms_to_ws_valid=0 in that same cycle and ms_valid=0 next cycle, even if es_to_ms_valid=1 and ms_allowin=1. The simultaneous accept is discarded.
- Reset mid-stall: ms_valid=0 on the next edge regardless of other inputs.

## Test plan
- LB stream: addr_lo 0..3, m=32'h80FF7F01, ld_type 1 -> final_result 00000001, 0000007F, FFFFFFFF, FFFFFF80; the same stream with LBU (ld_type 2) -> 01, 7F, FF, 80 zero-extended.
- LWL/LWR: rt=32'hAABBCCDD, m=32'h11223344. LWL addr_lo=1 -> 3344CCDD. LWR addr_lo=2 -> AABB1122. LWR addr_lo=0 -> 11223344.
- Backpressure: ws_allowin=0 for 3 cycles with ms_valid=1 -> ms_allowin=0, ms_to_ws_bus stable, and one WB transfer after release with no duplicate or drop.
- Flush: ws_ex=1 while es_to_ms_valid=1 and ms_valid=1 -> ms_to_ws_valid=0 that cycle, ms_valid=0 next cycle, and the incoming instruction is dropped. Repeat with ws_eret.
- Forwarding: a non-excepting instruction with ex=0, rf_we=F, dest=5 -> fwd_we=F, fwd_dest=5. The same instruction with ex=1 -> fwd_we=0 and ms_cancel=1. mfc0=1 -> mfc0_block=1.
- Reset asserted while stalled with valid data -> all outputs reach their reset values after one edge, and a new accept succeeds the next cycle.
